shift_add_mult_ctrl: RTL

//  Sequencer for the 8-bit shift-and-add multiplier. Owns the multiplicand (B), accumulator (ACC),

---
 rtl/shift_add_mult_pkg.sv | 13 +
 rtl/sam_acc_adder.sv | 13 +
 rtl/shift_add_mult_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared types and defaults for the shift-and-add multiplier sequencer.
package shift_add_mult_pkg;

    localparam int unsigned SAM_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sam_acc_adder.sv
// Combinational B + ACC adder with carry-out for the shift-and-add multiplier.
module sam_acc_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] acc_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_o
);

    assign {c_o, sum} = {1'b0, b_in} + {1'b0, acc_in};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for an unsigned shift-and-add multiplier: one ADD and one SHIFT per multiplier bit,
// product {ACC,Q} presented on a valid/ready output.
module shift_add_mult_ctrl
    import shift_add_mult_pkg::*;
#(
    parameter int unsigned WIDTH = SAM_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               abort,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             c;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             sum_c;

    // Adding zero when the current multiplier bit is clear keeps the ADD step uniform.
    assign add_b = q[0] ? b_reg : '0;

    sam_acc_adder #(
        .WIDTH (WIDTH)
    ) u_acc_adder (
        .b_in   (add_b),
        .acc_in (acc),
        .sum    (sum),
        .c_o    (sum_c)
    );

    always_ff @(posedge clk) begin
        // An abort of an in-flight multiply returns everything to the reset picture.
        if (!rst_n || (abort && (state == ADD || state == SHIFT))) begin
            state     <= IDLE;
            b_reg     <= '0;
            acc       <= '0;
            q         <= '0;
            c         <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_reg    <= b_in;
                        q        <= a_in;
                        acc      <= '0;
                        c        <= 1'b0;
                        count    <= '0;
                        state    <= ADD;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ADD: begin
                    {c, acc} <= {sum_c, sum};
                    state    <= SHIFT;
                end
                SHIFT: begin
                    {c, acc, q} <= {1'b0, c, acc, q[WIDTH-1:1]};
                    if (count == LAST_BIT) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        // Product is the post-shift {ACC,Q}; C is always shifted into ACC's MSB.
                        product   <= {c, acc, q[WIDTH-1:1]};
                    end else begin
                        count <= count + CNT_W'(1);
                        state <= ADD;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        product   <= '0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
